fifo_memory: RTL and testbench
==============================

// Module: fifo_memory
// PURPOSE
//  Single-clock circular FIFO buffer built on a register-array memory, with full, empty and
//  free-slot-count status. Sits between a producer and a consumer on the same clock domain.
//  TYPE selects how the flags see the opposite pointer:
//  - direct: the flags use the opposite pointer as it is now.
//  - synchronised: the opposite pointer is gray-coded and passed through 2 flops, which gives
//    conservative flags for use behind a future clock-crossing boundary.
// PARAMETERS
//  DATA_WIDTH  8  word width in bits
//  ADDR_WIDTH  5  log2 of depth; depth = 2**ADDR_WIDTH (32)
//  TYPE        0  0 = SYNCHRONOUS (direct flags), 1 = ASYNCHRONOUS (2-flop gray pointer sync)
// PORTS
//  clk         in   1             single clock; all state updates on its rising edge
//  rst         in   1             asynchronous, active-high reset
//  data_in     in   DATA_WIDTH    write word
//  wr_en       in   1             write request, sampled at posedge clk
//  FIFO_full   out  1             memory full; writes are ignored while high
//  avail       out  ADDR_WIDTH+1  free slots = 2**ADDR_WIDTH - occupancy (write-side view)
//  data_out    out  DATA_WIDTH    registered read word
//  rd_en       in   1             read request, sampled at posedge clk
//  FIFO_empty  out  1             memory empty; reads are ignored while high
// BEHAVIOUR
//  - Internal names are fixed for hierarchical bench access: mem[0:2**ADDR_WIDTH-1],
//    wptr and rptr. wptr and rptr are binary, ADDR_WIDTH+1 bits; the MSB is the wrap bit.
//  - Reset (async, rst=1): wptr=rptr=0, all sync flops=0, data_out=0, FIFO_empty=1,
//    FIFO_full=0, avail=2**ADDR_WIDTH. mem is not reset.
//  - Write: at posedge, if wr_en && !FIFO_full then mem[wptr[ADDR_WIDTH-1:0]]<=data_in and
//    wptr<=wptr+1. Otherwise the write is dropped silently; no state changes.
//  - Read: at posedge, if rd_en && !FIFO_empty then data_out<=mem[rptr[ADDR_WIDTH-1:0]] and
//    rptr<=rptr+1. Latency is 1 cycle. Otherwise data_out holds its last value.
//  - Pointers wrap naturally modulo 2**(ADDR_WIDTH+1).
//  - TYPE=0:
//    - FIFO_empty = (wptr==rptr).
//    - FIFO_full = (wptr[ADDR_WIDTH]!=rptr[ADDR_WIDTH]) && (low ADDR_WIDTH bits equal).
//    - Both are combinational from the pointers and valid the cycle after the update.
//  - TYPE=1:
//    - rptr is gray-coded and synchronised through 2 flops toward the write side; wptr the
//      same toward the read side. Each synced pointer is converted back to binary.
//    - FIFO_full is computed from wptr vs synced rptr; FIFO_empty from rptr vs synced wptr.
//    - Assertion is immediate (own pointer).
//    - Deassertion lags by 2 cycles: empty stays 1 for 2 cycles after the first write;
//      full stays 1 for 2 cycles after a read.
//  - avail = 2**ADDR_WIDTH - (wptr - rptr_view), where rptr_view is rptr for TYPE=0 and
//    synced rptr for TYPE=1. Range is 0..2**ADDR_WIDTH; avail==0 exactly when FIFO_full.
//  - Simultaneous wr_en and rd_en: each operation is qualified independently by the current
//    flags.
//    - When full: the read proceeds and the write is dropped.
//    - When empty: the write proceeds and the read is dropped.
//    - Otherwise both proceed and occupancy is unchanged.
//  - Reset mid-operation: pointers clear immediately; stored data is discarded logically.
// STRUCTURE
//  - Package fifo_pkg holds:
//    - constants SYNCHRONOUS=0 and ASYNCHRONOUS=1;
//    - functions bin2gray and gray2bin, parameterised by width.
//  - Sub-module ptr_sync_2ff: WIDTH-bit 2-flop synchroniser with async active-high reset to 0.
//    Instantiated twice when TYPE=1; bypassed via generate when TYPE=0.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=5, also run at TYPE=0 and TYPE=1)
//  1. Assert rst -> FIFO_empty=1, FIFO_full=0, avail=32, data_out=0, wptr=rptr=0.
//  2. 42 single-cycle writes of random values 0..40 -> first 32 land in mem[0..31];
//     FIFO_full=1 after the 32nd; writes 33-42 are dropped; wptr=6'b100000; avail=0.
//  3. Continue from 2 with 37 single-cycle reads -> data_out returns the 32 words in write
//     order; FIFO_empty=1 after the 32nd; reads 33-37 leave data_out and rptr=32 unchanged.
//  4. Wrap: reset, write 20, read 15, write 20 ->
//     - wptr=40 and rptr=15;
//     - mem[0..7] hold the last 8 writes;
//     - contents rptr..wptr equal the model queue.
//  5. 544 random ops (50/50 read/write), each checked against a queue model gated by the
//     model's flags -> mem[rptr..wptr) equals the queue after every op.
//  6. TYPE=1 latency:
//     - One write into an empty FIFO -> FIFO_empty stays 1 for 2 more cycles.
//     - One read from a full FIFO -> FIFO_full stays 1 for 2 more cycles.
//     - rst mid-burst -> flags and avail return to their reset values at once.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and gray-code helpers
// for the fifo_memory pointer logic.
package fifo_pkg;

  localparam int SYNCHRONOUS  = 0;
  localparam int ASYNCHRONOUS = 1;

  // Mask of the low w bits; helpers work on up to 32 bits.
  function automatic logic [31:0] width_mask(
    input int w
  );
    logic [31:0] m;
    if (w >= 32) m = '1;
    else         m = (32'd1 << w) - 32'd1;
    return m;
  endfunction

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b,
    input int          w
  );
    logic [31:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [31:0] gray2bin(
    input logic [31:0] g,
    input int          w
  );
    logic [31:0] gm;
    logic [31:0] b;
    gm = g & width_mask(w);
    b  = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) b = b ^ (gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// ptr_sync_2ff: two-flop synchroniser for a gray-coded
// pointer, async active-high reset to zero.
module ptr_sync_2ff #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_d, s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;

  // Next-stage values: each flop takes the one before it.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchroniser chain, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/fifo_memory.sv
// fifo_memory: single-clock circular FIFO on a register
// array with full/empty/free-slot status.
module fifo_memory
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int TYPE       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  output logic                  FIFO_full,
  output logic [ADDR_WIDTH:0]   avail,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rd_en,
  output logic                  FIFO_empty
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [PW-1:0] wptr_d, wptr_q;
  logic [PW-1:0] rptr_d, rptr_q;
  logic [PW-1:0] wptr, rptr;

  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;

  logic [PW-1:0] wptr_view;
  logic [PW-1:0] rptr_view;
  logic [PW-1:0] used;
  logic          do_wr;
  logic          do_rd;

  assign wptr = wptr_q;
  assign rptr = rptr_q;

  // Opposite-pointer view: direct, or gray 2-flop synced.
  generate
    if (TYPE == ASYNCHRONOUS) begin : g_async
      logic [PW-1:0] wgray, rgray;
      logic [PW-1:0] wgray_s, rgray_s;

      assign wgray = PW'(bin2gray(32'(wptr_q), PW));
      assign rgray = PW'(bin2gray(32'(rptr_q), PW));

      ptr_sync_2ff #(.WIDTH(PW)) u_w2r (
        .clk (clk),
        .rst (rst),
        .d   (wgray),
        .q   (wgray_s)
      );

      ptr_sync_2ff #(.WIDTH(PW)) u_r2w (
        .clk (clk),
        .rst (rst),
        .d   (rgray),
        .q   (rgray_s)
      );

      assign wptr_view = PW'(gray2bin(32'(wgray_s), PW));
      assign rptr_view = PW'(gray2bin(32'(rgray_s), PW));
    end else begin : g_sync
      assign wptr_view = wptr_q;
      assign rptr_view = rptr_q;
    end
  endgenerate

  // Status flags: own pointer against the opposite view.
  always_comb begin
    FIFO_empty = (wptr_view == rptr_q);
    FIFO_full  = (wptr_q[ADDR_WIDTH] !=
                  rptr_view[ADDR_WIDTH]) &&
                 (wptr_q[ADDR_WIDTH-1:0] ==
                  rptr_view[ADDR_WIDTH-1:0]);
    used       = wptr_q - rptr_view;
    avail      = PW'(DEPTH) - used;
  end

  // Qualify requests and compute next pointers and read word.
  always_comb begin
    do_wr      = wr_en && !FIFO_full;
    do_rd      = rd_en && !FIFO_empty;
    wptr_d     = wptr_q + PW'(do_wr);
    rptr_d     = rptr_q + PW'(do_rd);
    data_out_d = data_out_q;
    if (do_rd) begin
      data_out_d = mem[rptr_q[ADDR_WIDTH-1:0]];
    end
  end

  // Pointer and output registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      data_out_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_fifo_memory.sv
// tb_fifo_memory: random stimulus against a count/array
// reference model, both TYPE variants side by side.
module tb_fifo_memory;

  localparam int DEPTH = 32;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       wr_en;
  logic       rd_en;

  logic       fl [2];
  logic       em [2];
  logic [5:0] av [2];
  logic [7:0] dq [2];

  int n_chk;
  int n_err;

  int wc  [2];
  int rc  [2];
  int wd1 [2];
  int wd2 [2];
  int rd1 [2];
  int rd2 [2];
  logic [7:0] md [2];
  logic [7:0] mdata [2][1024];

  fifo_memory #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (5),
    .TYPE       (0)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .FIFO_full  (fl[0]),
    .avail      (av[0]),
    .data_out   (dq[0]),
    .rd_en      (rd_en),
    .FIFO_empty (em[0])
  );

  fifo_memory #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (5),
    .TYPE       (1)
  ) u_async (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .FIFO_full  (fl[1]),
    .avail      (av[1]),
    .data_out   (dq[1]),
    .rd_en      (rd_en),
    .FIFO_empty (em[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] hw_wptr(input int i);
    return (i != 0) ? u_async.wptr : u_sync.wptr;
  endfunction

  function automatic logic [5:0] hw_rptr(input int i);
    return (i != 0) ? u_async.rptr : u_sync.rptr;
  endfunction

  function automatic logic [7:0] mem_at(
    input int         i,
    input logic [4:0] a
  );
    return (i != 0) ? u_async.mem[a] : u_sync.mem[a];
  endfunction

  function automatic string nm(input int i);
    return (i != 0) ? "async" : "sync";
  endfunction

  // Opposite-pointer views: TYPE=1 sees counts two cycles old.
  function automatic int rview(input int i);
    return (i != 0) ? rd2[i] : rc[i];
  endfunction

  function automatic int wview(input int i);
    return (i != 0) ? wd2[i] : wc[i];
  endfunction

  function automatic logic m_full(input int i);
    return (wc[i] - rview(i)) == DEPTH;
  endfunction

  function automatic logic m_empty(input int i);
    return wview(i) == rc[i];
  endfunction

  function automatic int m_avail(input int i);
    return DEPTH - (wc[i] - rview(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      wc[i]  = 0;
      rc[i]  = 0;
      wd1[i] = 0;
      wd2[i] = 0;
      rd1[i] = 0;
      rd2[i] = 0;
      md[i]  = 8'h00;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic dw;
      logic dr;
      dw = wr_en && !m_full(i);
      dr = rd_en && !m_empty(i);
      rd2[i] = rd1[i];
      rd1[i] = rc[i];
      wd2[i] = wd1[i];
      wd1[i] = wc[i];
      if (dr) begin
        md[i] = mdata[i][rc[i] % 1024];
        rc[i] = rc[i] + 1;
      end
      if (dw) begin
        mdata[i][wc[i] % 1024] = data_in;
        wc[i] = wc[i] + 1;
      end
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 2; i++) begin
      chk({nm(i), "_empty"}, 32'(em[i]),
          32'(m_empty(i)));
      chk({nm(i), "_full"}, 32'(fl[i]),
          32'(m_full(i)));
      chk({nm(i), "_avail"}, 32'(av[i]),
          32'(m_avail(i)));
      chk({nm(i), "_dout"}, 32'(dq[i]), 32'(md[i]));
      chk({nm(i), "_wptr"}, 32'(hw_wptr(i)),
          32'(wc[i] % 64));
      chk({nm(i), "_rptr"}, 32'(hw_rptr(i)),
          32'(rc[i] % 64));
    end
  endtask

  task automatic check_reset_vals(input string t);
    for (int i = 0; i < 2; i++) begin
      chk({t, nm(i), "_empty"}, 32'(em[i]), 32'd1);
      chk({t, nm(i), "_full"}, 32'(fl[i]), 32'd0);
      chk({t, nm(i), "_avail"}, 32'(av[i]), 32'd32);
      chk({t, nm(i), "_dout"}, 32'(dq[i]), 32'd0);
      chk({t, nm(i), "_wptr"}, 32'(hw_wptr(i)), 32'd0);
      chk({t, nm(i), "_rptr"}, 32'(hw_rptr(i)), 32'd0);
    end
  endtask

  task automatic check_mem_queue(input string t);
    for (int i = 0; i < 2; i++) begin
      logic ok;
      ok = 1'b1;
      for (int k = rc[i]; k < wc[i]; k++) begin
        if (mem_at(i, 5'(k % 32)) !==
            mdata[i][k % 1024]) ok = 1'b0;
      end
      chk({t, nm(i), "_memq"}, 32'(ok), 32'd1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    model_reset();
    check_reset_vals("rst_");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_reset_vals("init_");
    check_outs();
    @(negedge clk);
    rst = 1'b0;

    // Fill past capacity: 32 land, 10 dropped.
    wr_en = 1'b1;
    repeat (42) begin
      data_in = 8'($urandom_range(0, 40));
      cycle();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk({nm(i), "_fill_wptr"}, 32'(hw_wptr(i)),
          32'd32);
      chk({nm(i), "_fill_full"}, 32'(fl[i]), 32'd1);
      chk({nm(i), "_fill_avail"}, 32'(av[i]), 32'd0);
      for (int k = 0; k < 32; k++) begin
        chk({nm(i), "_fill_mem"}, 32'(mem_at(i, 5'(k))),
            32'(mdata[i][k]));
      end
    end

    // Drain past empty: 32 returned in order, 5 dropped.
    rd_en = 1'b1;
    repeat (37) cycle();
    rd_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk({nm(i), "_drain_rptr"}, 32'(hw_rptr(i)),
          32'd32);
      chk({nm(i), "_drain_empty"}, 32'(em[i]), 32'd1);
      chk({nm(i), "_drain_last"}, 32'(dq[i]),
          32'(mdata[i][31]));
    end

    // Wrap: write 20, read 15, write 20.
    do_reset();
    wr_en = 1'b1;
    repeat (20) begin
      data_in = 8'($urandom);
      cycle();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    repeat (15) cycle();
    rd_en = 1'b0;
    wr_en = 1'b1;
    repeat (20) begin
      data_in = 8'($urandom);
      cycle();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk({nm(i), "_wrap_wptr"}, 32'(hw_wptr(i)),
          32'd40);
      chk({nm(i), "_wrap_rptr"}, 32'(hw_rptr(i)),
          32'd15);
      for (int k = 0; k < 8; k++) begin
        chk({nm(i), "_wrap_low"}, 32'(mem_at(i, 5'(k))),
            32'(mdata[i][32 + k]));
      end
    end
    check_mem_queue("wrap_");

    // Random single ops, half reads and half writes.
    repeat (544) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = !wr_en;
      data_in = 8'($urandom);
      cycle();
      check_mem_queue("rnd_");
    end

    // Mixed simultaneous traffic, biased toward full then empty.
    for (int ph = 0; ph < 2; ph++) begin
      repeat (150) begin
        wr_en   = ($urandom_range(0, 3) != 0) ^ 1'(ph);
        rd_en   = ($urandom_range(0, 3) == 0) ^ 1'(ph);
        data_in = 8'($urandom);
        cycle();
      end
      check_mem_queue("mix_");
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Empty deassert lag after the first write.
    do_reset();
    wr_en   = 1'b1;
    data_in = 8'h5a;
    cycle();
    wr_en = 1'b0;
    chk("lag_async_empty0", 32'(em[1]), 32'd1);
    chk("lag_sync_empty0", 32'(em[0]), 32'd0);
    cycle();
    chk("lag_async_empty1", 32'(em[1]), 32'd1);
    cycle();
    chk("lag_async_empty2", 32'(em[1]), 32'd0);

    // Full deassert lag after one read.
    wr_en = 1'b1;
    repeat (31) begin
      data_in = 8'($urandom);
      cycle();
    end
    wr_en = 1'b0;
    repeat (3) cycle();
    chk("lag_async_full_pre", 32'(fl[1]), 32'd1);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    chk("lag_async_full0", 32'(fl[1]), 32'd1);
    chk("lag_sync_full0", 32'(fl[0]), 32'd0);
    chk("lag_dout", 32'(dq[1]), 32'h5a);
    cycle();
    chk("lag_async_full1", 32'(fl[1]), 32'd1);
    cycle();
    chk("lag_async_full2", 32'(fl[1]), 32'd0);

    // Reset in the middle of a burst takes effect at once.
    wr_en = 1'b1;
    rd_en = 1'b1;
    repeat (3) begin
      data_in = 8'($urandom);
      cycle();
    end
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_");
    model_reset();
    @(negedge clk);
    rst   = 1'b0;
    rd_en = 1'b0;
    data_in = 8'hc3;
    cycle();
    wr_en = 1'b0;
    repeat (3) cycle();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    chk("post_rst_dout", 32'(dq[0]), 32'hc3);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
